// File: rtl/spi_pkg.sv
`default_nettype none
// spi_pkg: state encoding and length-field width helper shared by the SPI shift engine files.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } spi_state_e;

   // Width needed to hold the values 0..n (length field, bit counter).
   function automatic int spi_len_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_dir_shift_reg.sv
`default_nettype none
// spi_dir_shift_reg: loadable shift register with runtime direction (0 = left, 1 = right).
module spi_dir_shift_reg
   import spi_pkg::*;
#(
   parameter int nbits = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_en_i,
   input  logic [nbits-1:0] load_data_i,
   input  logic             shift_en_i,
   input  logic             dir_i,
   input  logic             in_i,
   output logic [nbits-1:0] data_o
);

   logic [nbits-1:0] data_q, data_d;

   // Load wins over shift so a new frame can start regardless of a stray strobe.
   always_comb begin
      data_d = data_q;
      if (load_en_i) begin
         data_d = load_data_i;
      end else if (shift_en_i) begin
         data_d = dir_i ? {in_i, data_q[nbits-1:1]} : {data_q[nbits-2:0], in_i};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// spi_shift_engine: SPI data path with runtime frame length, bit order and val/rdy handshakes.
module spi_shift_engine
   import spi_pkg::*;
#(
   parameter int nbits = 32,
   parameter int LW    = spi_len_width(nbits)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             send_val,
   output logic             send_rdy,
   input  logic [nbits-1:0] send_data,
   input  logic [LW-1:0]    send_len,
   input  logic             send_lsb_first,
   input  logic             bit_en,
   input  logic             miso,
   output logic             mosi,
   output logic             busy,
   output logic             recv_val,
   input  logic             recv_rdy,
   output logic [nbits-1:0] recv_data
);

   localparam logic [LW-1:0] NBITS_L = LW'(nbits);

   spi_state_e       state_q, state_d;
   logic [LW-1:0]    cnt_q, cnt_d;
   logic [LW-1:0]    len_q, len_d;
   logic             lsb_q, lsb_d;

   logic [LW-1:0]    eff_len;
   logic [nbits-1:0] tx_load;
   logic [nbits-1:0] tx_data;
   logic [nbits-1:0] rx_data;
   logic             load_en;
   logic             shift_en;

   assign eff_len  = (send_len == '0) ? NBITS_L : send_len;
   // MSB-first frames are left-aligned so the first bit always sits at the MSB.
   assign tx_load  = send_lsb_first ? send_data : (send_data << (NBITS_L - eff_len));
   assign load_en  = (state_q == IDLE) && send_val;
   assign shift_en = (state_q == SHIFT) && bit_en;

   spi_dir_shift_reg #(.nbits(nbits)) u_tx (
      .clk         (clk),
      .reset       (reset),
      .load_en_i   (load_en),
      .load_data_i (tx_load),
      .shift_en_i  (shift_en),
      .dir_i       (lsb_q),
      .in_i        (1'b0),
      .data_o      (tx_data)
   );

   spi_dir_shift_reg #(.nbits(nbits)) u_rx (
      .clk         (clk),
      .reset       (reset),
      .load_en_i   (load_en),
      .load_data_i ('0),
      .shift_en_i  (shift_en),
      .dir_i       (lsb_q),
      .in_i        (miso),
      .data_o      (rx_data)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      lsb_d    = lsb_q;
      send_rdy = 1'b0;
      busy     = 1'b0;
      recv_val = 1'b0;
      case (state_q)
         IDLE: begin
            send_rdy = 1'b1;
            if (send_val) begin
               len_d   = eff_len;
               lsb_d   = send_lsb_first;
               cnt_d   = eff_len;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (bit_en) begin
               cnt_d = cnt_q - LW'(1);
               if (cnt_q == LW'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            recv_val = 1'b1;
            if (recv_rdy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         lsb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         lsb_q   <= lsb_d;
      end
   end

   assign mosi = (state_q == SHIFT) && (lsb_q ? tx_data[0] : tx_data[nbits-1]);
   // LSB-first data accumulates from the top, so short frames are right-aligned here.
   assign recv_data = (state_q != DONE) ? '0 :
                      (lsb_q ? (rx_data >> (NBITS_L - len_q)) : rx_data);

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`default_nettype none
// tb_spi_shift_engine: randomized self-checking bench for spi_shift_engine with nbits = 8.
module tb_spi_shift_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       send_val;
   logic       send_rdy;
   logic [7:0] send_data;
   logic [3:0] send_len;
   logic       send_lsb_first;
   logic       bit_en;
   logic       miso;
   logic       mosi;
   logic       busy;
   logic       recv_val;
   logic       recv_rdy;
   logic [7:0] recv_data;
   logic       loop_en;
   logic       miso_drv;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign miso = loop_en ? mosi : miso_drv;

   spi_shift_engine #(.nbits(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .send_val       (send_val),
      .send_rdy       (send_rdy),
      .send_data      (send_data),
      .send_len       (send_len),
      .send_lsb_first (send_lsb_first),
      .bit_en         (bit_en),
      .miso           (miso),
      .mosi           (mosi),
      .busy           (busy),
      .recv_val       (recv_val),
      .recv_rdy       (recv_rdy),
      .recv_data      (recv_data)
   );

   always @(posedge clk) begin
      if (!reset && send_val && send_rdy)
         assert (send_len <= 4'd8) else $error("illegal send_len %0d accepted", send_len);
   end

   // Reference: k-th transmitted bit and the word assembled from the k-th received bits.
   function automatic logic [7:0] model_mosi(input logic [7:0] d, input int eff, input logic lsb);
      logic [7:0] s;
      s = 8'h00;
      for (int k = 0; k < eff; k++) s[k] = lsb ? d[k] : d[eff-1-k];
      return s;
   endfunction

   function automatic logic [7:0] model_recv(input logic [7:0] b, input int eff, input logic lsb);
      int v;
      v = 0;
      for (int k = 0; k < eff; k++) if (b[k]) v += lsb ? (1 << k) : (1 << (eff - 1 - k));
      return v[7:0];
   endfunction

   // Runs one frame; returns the mosi bit sequence (bit k = k-th bit) and the received word.
   task automatic do_frame(input logic [7:0] d, input logic [3:0] len, input logic lsb,
                           input logic loop, input logic [7:0] mbits, input int gap,
                           input bit accept, output logic [7:0] mseq, output logic [7:0] rdata,
                           output int hs_err, output int lat_err);
      int   eff;
      logic m0;
      eff     = (len == 4'd0) ? 8 : int'(len);
      hs_err  = 0;
      lat_err = 0;
      mseq    = 8'h00;
      @(negedge clk);
      if (send_rdy !== 1'b1) hs_err++;
      send_data = d; send_len = len; send_lsb_first = lsb; loop_en = loop; send_val = 1'b1;
      @(negedge clk);
      send_val       = 1'b0;
      send_len       = 4'($urandom_range(0, 8));
      send_lsb_first = ~lsb;
      send_data      = 8'($urandom);
      for (int k = 0; k < eff; k++) begin
         m0 = mosi;
         for (int g = 1; g < gap; g++) begin
            if (busy !== 1'b1 || send_rdy !== 1'b0 || recv_val !== 1'b0 || mosi !== m0) hs_err++;
            @(negedge clk);
         end
         if (busy !== 1'b1 || send_rdy !== 1'b0 || recv_val !== 1'b0) hs_err++;
         mseq[k]  = mosi;
         miso_drv = mbits[k];
         bit_en   = 1'b1;
         @(negedge clk);
         bit_en = 1'b0;
      end
      if (recv_val !== 1'b1 || busy !== 1'b0 || send_rdy !== 1'b0) lat_err++;
      if (mosi !== 1'b0) hs_err++;
      rdata = recv_data;
      if (accept) begin
         recv_rdy = 1'b1;
         @(negedge clk);
         recv_rdy = 1'b0;
         if (send_rdy !== 1'b1 || recv_val !== 1'b0) lat_err++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; send_val = 1'b0; send_data = 8'h00; send_len = 4'd0;
      send_lsb_first = 1'b0; bit_en = 1'b0; miso_drv = 1'b0; loop_en = 1'b0; recv_rdy = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({send_rdy, recv_val, busy, mosi} !== 4'b1000 || recv_data !== 8'h00) begin
         bad++;
         $display("FAIL reset outputs: rdy/val/busy/mosi=%b data=%h want 1000 data=00",
                  {send_rdy, recv_val, busy, mosi}, recv_data);
      end
      reset = 1'b0;
   endtask

   task automatic test_loopback_msb;
      logic [7:0] ms, rd; int he, le;
      do_frame(8'h1E, 4'd8, 1'b0, 1'b1, 8'h00, 2, 1'b1, ms, rd, he, le);
      total++; if (ms !== 8'h78) begin bad++; $display("FAIL msb_loop mosi: got %h want 78", ms); end
      total++; if (rd !== 8'h1E) begin bad++; $display("FAIL msb_loop data: got %h want 1e", rd); end
      total++; if (he !== 0 || le !== 0) begin bad++; $display("FAIL msb_loop handshake: errs %0d/%0d want 0/0", he, le); end
   endtask

   task automatic test_loopback_lsb;
      logic [7:0] ms, rd; int he, le;
      do_frame(8'h1E, 4'd8, 1'b1, 1'b1, 8'h00, 2, 1'b1, ms, rd, he, le);
      total++; if (ms !== 8'h1E) begin bad++; $display("FAIL lsb_loop mosi: got %h want 1e", ms); end
      total++; if (rd !== 8'h1E) begin bad++; $display("FAIL lsb_loop data: got %h want 1e", rd); end
      total++; if (he !== 0 || le !== 0) begin bad++; $display("FAIL lsb_loop handshake: errs %0d/%0d want 0/0", he, le); end
   endtask

   task automatic test_short_frame;
      logic [7:0] ms, rd; int he, le;
      do_frame(8'h13, 4'd5, 1'b0, 1'b0, 8'hFF, 2, 1'b1, ms, rd, he, le);
      total++; if (ms !== 8'h19) begin bad++; $display("FAIL len5 mosi: got %h want 19", ms); end
      total++; if (rd !== 8'h1F) begin bad++; $display("FAIL len5 data: got %h want 1f", rd); end
      total++; if (he !== 0 || le !== 0) begin bad++; $display("FAIL len5 handshake: errs %0d/%0d want 0/0", he, le); end
   endtask

   task automatic test_len0;
      logic [7:0] ms, rd; int he, le;
      do_frame(8'hA5, 4'd0, 1'b1, 1'b0, 8'hCC, 1, 1'b1, ms, rd, he, le);
      total++; if (ms !== 8'hA5) begin bad++; $display("FAIL len0 mosi: got %h want a5", ms); end
      total++; if (rd !== 8'hCC) begin bad++; $display("FAIL len0 data: got %h want cc", rd); end
      total++; if (he !== 0 || le !== 0) begin bad++; $display("FAIL len0 strobe count: errs %0d/%0d want 0/0", he, le); end
   endtask

   task automatic test_backpressure;
      logic [7:0] ms, rd; int he, le;
      do_frame(8'hC3, 4'd8, 1'b0, 1'b1, 8'h00, 1, 1'b0, ms, rd, he, le);
      total++; if (rd !== 8'hC3 || le !== 0) begin bad++; $display("FAIL bp first data: got %h lat %0d want c3 0", rd, le); end
      for (int c = 0; c < 4; c++) begin
         send_val = 1'b1; send_data = 8'hFF; send_len = 4'd8; bit_en = c[0]; recv_rdy = 1'b0;
         @(negedge clk);
         total++;
         if ({recv_val, send_rdy, busy, mosi} !== 4'b1000 || recv_data !== 8'hC3) begin
            bad++;
            $display("FAIL bp hold cycle %0d: val/rdy/busy/mosi=%b data=%h want 1000 c3",
                     c, {recv_val, send_rdy, busy, mosi}, recv_data);
         end
      end
      send_val = 1'b0; bit_en = 1'b0; recv_rdy = 1'b1;
      @(negedge clk);
      recv_rdy = 1'b0;
      total++;
      if ({send_rdy, recv_val, busy} !== 3'b100) begin
         bad++; $display("FAIL bp release: rdy/val/busy=%b want 100", {send_rdy, recv_val, busy});
      end
      do_frame(8'h96, 4'd8, 1'b1, 1'b1, 8'h00, 2, 1'b1, ms, rd, he, le);
      total++; if (rd !== 8'h96 || he !== 0 || le !== 0) begin bad++; $display("FAIL bp next frame: got %h errs %0d/%0d want 96 0/0", rd, he, le); end
   endtask

   task automatic test_reset_midframe;
      logic [7:0] ms, rd; int he, le;
      @(negedge clk);
      send_data = 8'hF0; send_len = 4'd8; send_lsb_first = 1'b0; loop_en = 1'b1; send_val = 1'b1;
      @(negedge clk);
      send_val = 1'b0;
      repeat (3) begin
         bit_en = 1'b1; @(negedge clk); bit_en = 1'b0; @(negedge clk);
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL midframe busy: got %b want 1", busy); end
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({send_rdy, busy, mosi, recv_val} !== 4'b1000 || recv_data !== 8'h00) begin
         bad++;
         $display("FAIL midframe abort: rdy/busy/mosi/val=%b data=%h want 1000 00",
                  {send_rdy, busy, mosi, recv_val}, recv_data);
      end
      reset = 1'b0;
      do_frame(8'h5A, 4'd8, 1'b0, 1'b1, 8'h00, 2, 1'b1, ms, rd, he, le);
      total++; if (rd !== 8'h5A || he !== 0 || le !== 0) begin bad++; $display("FAIL after abort: got %h errs %0d/%0d want 5a 0/0", rd, he, le); end
   endtask

   task automatic test_random;
      logic [7:0] ms, rd, d, mb, exp_ms, exp_rd;
      logic [3:0] len;
      logic       lsb, loop;
      int         he, le, eff, gap;
      for (int i = 0; i < 40; i++) begin
         d    = 8'($urandom);
         len  = 4'($urandom_range(0, 8));
         lsb  = 1'($urandom);
         loop = 1'($urandom);
         mb   = 8'($urandom);
         gap  = $urandom_range(1, 3);
         eff  = (len == 4'd0) ? 8 : int'(len);
         exp_ms = model_mosi(d, eff, lsb);
         exp_rd = model_recv(loop ? exp_ms : mb, eff, lsb);
         do_frame(d, len, lsb, loop, mb, gap, 1'b1, ms, rd, he, le);
         total++;
         if (ms !== exp_ms || rd !== exp_rd || he !== 0 || le !== 0) begin
            bad++;
            $display("FAIL random #%0d d=%h len=%0d lsb=%b loop=%b: mosi %h data %h errs %0d/%0d want %h %h 0/0",
                     i, d, len, lsb, loop, ms, rd, he, le, exp_ms, exp_rd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_loopback_msb();
      test_loopback_lsb();
      test_short_frame();
      test_len0();
      test_backpressure();
      test_reset_midframe();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit reached");
   end

endmodule
`default_nettype wire

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Parametrised SPI data-path engine; successor to the plain N-bit shift register.
- Adds runtime frame length (1..nbits), MSB/LSB-first order, and an internal bit counter.
- Uses val/rdy handshakes on the request and response sides.
- Sits between the SPI master/minion control FSM (which supplies the bit_en strobes) and the packet layer.

Parameters:
- nbits, 32, maximum frame width in bits (>= 2).
- LW, $clog2(nbits+1), width of the length field (derived; do not override).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- send_val  input  1  transfer request valid
- send_rdy  output  1  engine can accept a request
- send_data  input  nbits  TX payload, right-aligned (bits [len-1:0] used)
- send_len  input  LW  frame length; 0 encodes nbits
- send_lsb_first  input  1  1 = LSB first, 0 = MSB first
- bit_en  input  1  one-cycle strobe: sample miso and advance mosi
- miso  input  1  serial in
- mosi  output  1  serial out
- busy  output  1  high in SHIFT
- recv_val  output  1  RX word valid
- recv_rdy  input  1  consumer ready
- recv_data  output  nbits  RX word, right-aligned, upper bits zero

Behaviour:
- Reset: state IDLE; tx_reg, rx_reg and cnt cleared; send_rdy=1, recv_val=0, busy=0, mosi=0, recv_data=0.
- A reset in any state, including mid-frame, aborts to IDLE in one cycle and discards partial data.
- States:
  - IDLE: send_rdy=1. On send_val & send_rdy:
    - latch eff_len (send_len==0 ? nbits : send_len) and the order bit;
    - load tx_reg: MSB-first -> send_data << (nbits-eff_len) (left-aligned); LSB-first -> send_data;
    - clear rx_reg; cnt=eff_len; go to SHIFT.
  - SHIFT: busy=1, send_rdy=0. mosi is combinational: tx_reg[nbits-1] (MSB-first) or tx_reg[0] (LSB-first). On bit_en, in the same edge:
    - sample miso into rx_reg (MSB-first: shift left, insert at bit 0; LSB-first: shift right, insert at bit nbits-1);
    - shift tx_reg toward the mosi end, filling with 0;
    - cnt--.
    - bit_en with cnt==1 -> DONE.
    - No bit_en -> all registers hold.
  - DONE: recv_val=1.
    - recv_data = rx_reg (MSB-first), or rx_reg >> (nbits-eff_len) (LSB-first). In both cases the first-received bit lands at bit eff_len-1 (MSB-first) or bit 0 (LSB-first).
    - On recv_rdy -> IDLE.
    - recv_val and recv_data stay stable until accepted.
- Latency: eff_len bit_en strobes from accept to DONE; recv_val rises the cycle after the last strobe.
- mosi=0 in IDLE and DONE.
- bit_en is ignored in IDLE and DONE.
- send_val is ignored outside IDLE; send_rdy is 0 in SHIFT and DONE, so a new request and a pending response never overlap.
- send_len > nbits is illegal; a bench assertion flags it, and RTL behaviour is undefined.
- Input changes on send_lsb_first or send_len after acceptance have no effect; the values latched at acceptance are used.
- Loopback (miso tied to mosi) returns recv_data == send_data[eff_len-1:0] for both bit orders.

Decomposition:
- Shared package spi_pkg:
  - state enum {IDLE, SHIFT, DONE}, 2 bits;
  - localparam helper for LW.
- One natural sub-module: spi_dir_shift_reg.
  - nbits-wide register with load_en/load_data, shift_en, a dir input (0 = left, 1 = right) and serial in_.
  - Load has priority over shift.
  - Instantiated twice: TX and RX.
- Counter, length latch, alignment and FSM live in spi_shift_engine.

Test Plan:
- nbits=8, len=8, MSB-first, send_data=0x1E, miso=mosi loopback, bit_en every 2nd cycle -> mosi 0,0,0,1,1,1,1,0; recv_data=0x1E after 8 strobes; busy high for the whole frame.
- Same request but LSB-first -> mosi 0,1,1,1,1,0,0,0; recv_data=0x1E.
- len=5, MSB-first, send_data=0x13, miso held 1 -> mosi 1,0,0,1,1; recv_data=0x1F; bits [7:5] zero.
- len=0 (encodes 8), LSB-first, send_data=0xA5, miso driven 0,0,1,1,0,0,1,1 -> exactly 8 strobes consumed; recv_data=0xCC.
- Backpressure: recv_rdy low 4 cycles in DONE while send_val=1 -> recv_val and recv_data stable, send_rdy=0, extra bit_en ignored; recv_rdy=1 -> IDLE next cycle, next request accepted.
- Reset asserted after 3 strobes of an 8-bit frame -> next cycle IDLE, send_rdy=1, busy=0, mosi=0, recv_val=0; a following loopback 0x5A transfer returns 0x5A.
